// File: rtl/dmem_pkg.sv
// Shared encodings for the MIPS32 MEM-stage data memory: access sizes,
// handshake FSM states and the wait-state counter width.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size 11 behaves as a word, so anything that is not byte/half needs a[1:0]=00.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Little-endian byte-lane steering: store mask/data replication on the write
// side and lane extraction with sign/zero extension on the read side.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_lo,
    input  logic [31:0] wr_data_in,
    output logic [3:0]  wr_mask,
    output logic [31:0] wr_data,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_lo,
    input  logic        rd_uns,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        ext_bit;

    // Replicated data lets the mask alone decide which lanes land in the word.
    always_comb begin
        wr_mask = 4'b1111;
        wr_data = wr_data_in;
        case (wr_size)
            SZ_B: begin
                wr_mask = 4'b0001 << wr_lo;
                wr_data = {4{wr_data_in[7:0]}};
            end
            SZ_H: begin
                wr_mask = wr_lo[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wr_data_in[15:0]}};
            end
            default: begin
                wr_mask = 4'b1111;
                wr_data = wr_data_in;
            end
        endcase
    end

    always_comb begin
        byte_sel = rd_word[{rd_lo, 3'b000} +: 8];
        half_sel = rd_lo[1] ? rd_word[31:16] : rd_word[15:0];
        ext_bit  = 1'b0;
        rd_data  = rd_word;
        case (rd_size)
            SZ_B: begin
                ext_bit = ~rd_uns & byte_sel[7];
                rd_data = {{24{ext_bit}}, byte_sel};
            end
            SZ_H: begin
                ext_bit = ~rd_uns & half_sel[15];
                rd_data = {{16{ext_bit}}, half_sel};
            end
            default: rd_data = rd_word;
        endcase
    end

endmodule

// File: rtl/dmem_rw.sv
// MEM-stage data memory with req/done handshake and WAIT_STATES wait cycles.
// Define DMEM_MISALIGN_TRAP_EN to flag (and suppress) misaligned accesses via err.
module dmem_rw
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [AW+1:0]      addr_q, addr_d;
    logic [31:0]        wd_q, wd_d;
    logic [1:0]         ld_size_q, ld_size_d;
    logic [1:0]         ld_lo_q, ld_lo_d;
    logic               ld_uns_q, ld_uns_d;

    logic               eff_we;
    logic [1:0]         eff_size;
    logic               eff_uns;
    logic [AW+1:0]      eff_addr;
    logic [31:0]        eff_wd;
    logic [AW-1:0]      eff_idx;
    logic               commit;
    logic               mis;
    logic               wr_en;
    logic               rd_en;
    logic [3:0]         wr_mask;
    logic [31:0]        wr_data;
    logic [31:0]        rword;

    logic unused_a_hi;
    assign unused_a_hi = &{1'b0, a[31:AW+2]};

    // With zero wait states the commit edge is the accept edge, so the access
    // must be taken straight from the ports while still in IDLE.
    always_comb begin
        eff_we   = we_q;
        eff_size = size_q;
        eff_uns  = uns_q;
        eff_addr = addr_q;
        eff_wd   = wd_q;
        if (state_q == ST_IDLE) begin
            eff_we   = we;
            eff_size = size;
            eff_uns  = uns;
            eff_addr = a[AW+1:0];
            eff_wd   = wd;
        end
    end

    assign eff_idx = eff_addr[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d   = we;
                    size_d = size;
                    uns_d  = uns;
                    addr_d = a[AW+1:0];
                    wd_d   = wd;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign commit = (state_d == ST_RESP) && (state_q != ST_RESP) && !reset;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q, err_d;
    assign mis   = is_misaligned(eff_size, eff_addr[1:0]);
    assign err_d = commit ? mis : err_q;
    assign err   = done & err_q;
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign mis = 1'b0;
    assign err = 1'b0;
`endif

    assign wr_en = commit &&  eff_we && !mis;
    assign rd_en = commit && !eff_we && !mis;

    // Extraction attributes follow the last completed load so rd holds across stores.
    always_comb begin
        ld_size_d = ld_size_q;
        ld_lo_d   = ld_lo_q;
        ld_uns_d  = ld_uns_q;
        if (rd_en) begin
            ld_size_d = eff_size;
            ld_lo_d   = eff_addr[1:0];
            ld_uns_d  = eff_uns;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            ld_size_q <= SZ_B;
            ld_lo_q   <= 2'b00;
            ld_uns_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            ld_size_q <= ld_size_d;
            ld_lo_q   <= ld_lo_d;
            ld_uns_q  <= ld_uns_d;
        end
    end

    dmem_lane u_lane (
        .wr_size    (eff_size),
        .wr_lo      (eff_addr[1:0]),
        .wr_data_in (eff_wd),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .rd_size    (ld_size_q),
        .rd_lo      (ld_lo_q),
        .rd_uns     (ld_uns_q),
        .rd_word    (rword),
        .rd_data    (rd)
    );

    // One byte-wide RAM per lane gives a natural per-byte write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_ram
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rd_q;

        always_ff @(posedge clk) begin
            if (wr_en && wr_mask[gi]) lane_mem[eff_idx] <= wr_data[8*gi +: 8];
        end

        always_ff @(posedge clk) begin
            if (reset)      lane_rd_q <= 8'h00;
            else if (rd_en) lane_rd_q <= lane_mem[eff_idx];
        end

        assign rword[8*gi +: 8] = lane_rd_q;
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_RESP);

endmodule
